mem_arbiter: RTL and testbench

- Parametrised N-channel successor to the fixed two-port (instruction/data) memory interface of the core.
- Merges CHANNELS requesters (ifetch, dmem, debug, DMA, ...) onto one downstream memory port, using the same valid/instr/addr/wdata/wstrb -> rdata/ready protocol.
- Registered grant FSM, fixed-priority arbitration by default, optional round-robin.
- Per-transaction watchdog that returns an error-ready to the requester if the downstream port stalls.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// N-channel request arbiter onto a single downstream memory port, with optional watchdog.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module mem_arbiter #(
   parameter int CHANNELS   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [CHANNELS-1:0]            req_valid,
   input  logic [CHANNELS-1:0]            req_instr,
   input  logic [CHANNELS*ADDR_WIDTH-1:0] req_addr,
   input  logic [CHANNELS*DATA_WIDTH-1:0] req_wdata,
   input  logic [CHANNELS*DATA_WIDTH/8-1:0] req_wstrb,
   output logic [DATA_WIDTH-1:0]          req_rdata,
   output logic [CHANNELS-1:0]            req_ready,
   output logic [CHANNELS-1:0]            req_error,
   output logic                           mem_valid,
   output logic                           mem_instr,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic [DATA_WIDTH-1:0]          mem_wdata,
   output logic [DATA_WIDTH/8-1:0]        mem_wstrb,
   input  logic [DATA_WIDTH-1:0]          mem_rdata,
   input  logic                           mem_ready
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // The watchdog fires in the BUSY cycle whose increment would reach TIMEOUT,
   // so mem_valid is high for exactly TIMEOUT cycles before the error pulse.
   localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         grant_q, grant_d;
   logic [WW-1:0]         wd_cnt_q, wd_cnt_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_instr_q, mem_instr_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]         mem_wstrb_q, mem_wstrb_d;
   logic [CHANNELS-1:0]   req_ready_q, req_ready_d;
   logic [CHANNELS-1:0]   req_error_q, req_error_d;
   logic [DATA_WIDTH-1:0] req_rdata_q, req_rdata_d;

   logic [CHANNELS-1:0]   elig;
   logic                  any_req;
   logic [CW-1:0]         win;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CHANNELS-1:0]   rot;
   logic [CW:0]           off, sum;
`endif

   // The channel completing this cycle is masked so its held request is not reissued.
   always_comb begin
      elig    = req_valid & ~req_ready_q;
      any_req = |elig;
      win     = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      rot = CHANNELS'({elig, elig} >> rr_ptr_q);
      off = '0;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (rot[i]) off = (CW+1)'(i);
      sum = {1'b0, rr_ptr_q} + off;
      if (sum >= (CW+1)'(CHANNELS)) sum = sum - (CW+1)'(CHANNELS);
      win = sum[CW-1:0];
`else
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (elig[i]) win = CW'(i);
`endif
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      wd_cnt_d    = wd_cnt_q;
      mem_valid_d = mem_valid_q;
      mem_instr_d = mem_instr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      req_ready_d = '0;
      req_error_d = '0;
      req_rdata_d = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = BUSY;
               grant_d     = win;
               wd_cnt_d    = '0;
               mem_valid_d = 1'b1;
               mem_instr_d = req_instr[win];
               mem_addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
               mem_wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
               mem_wstrb_d = req_wstrb[win*SW +: SW];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
               rr_ptr_d    = (win == CW'(CHANNELS - 1)) ? '0 : win + 1'b1;
`endif
            end
         end
         BUSY: begin
            if (mem_ready) begin
               req_ready_d[grant_q] = 1'b1;
               req_rdata_d          = mem_rdata;
               mem_valid_d          = 1'b0;
               state_d              = IDLE;
            end else if (TIMEOUT > 0 && wd_cnt_q == WD_LAST) begin
               req_ready_d[grant_q] = 1'b1;
               req_error_d[grant_q] = 1'b1;
               mem_valid_d          = 1'b0;
               state_d              = IDLE;
            end else if (TIMEOUT > 0) begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         wd_cnt_q    <= '0;
         mem_valid_q <= 1'b0;
         mem_instr_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         req_ready_q <= '0;
         req_error_q <= '0;
         req_rdata_q <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         wd_cnt_q    <= wd_cnt_d;
         mem_valid_q <= mem_valid_d;
         mem_instr_q <= mem_instr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         req_ready_q <= req_ready_d;
         req_error_q <= req_error_d;
         req_rdata_q <= req_rdata_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign mem_valid = mem_valid_q;
   assign mem_instr = mem_instr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign req_ready = req_ready_q;
   assign req_error = req_error_q;
   assign req_rdata = req_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions, a contention sequence
// with a hand-derived grant order, and reset during BUSY; completions go through a scoreboard.
module tb_mem_arbiter;
   localparam int CH = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [CH-1:0]     req_valid, req_instr;
   logic [CH*AW-1:0]  req_addr;
   logic [CH*DW-1:0]  req_wdata;
   logic [CH*SW-1:0]  req_wstrb;
   logic [DW-1:0]     req_rdata;
   logic [CH-1:0]     req_ready, req_error;
   logic              mem_valid, mem_instr;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [SW-1:0]     mem_wstrb;
   logic [DW-1:0]     mem_rdata;
   logic              mem_ready;

   always #5 clock = ~clock;

   mem_arbiter #(.CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata),
      .req_ready(req_ready), .req_error(req_error),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   typedef struct {
      int          ch;
      logic [DW-1:0] rdata;
      logic        err;
   } sb_t;

   typedef struct {
      int            ch;
      logic          instr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      int            lat;      // BUSY cycle in which mem_ready is driven (99 = never)
      logic [DW-1:0] rdata;
      logic          exp_err;
      int            exp_busy;
   } vec_t;

   sb_t  sbq[$];
   vec_t vecs[6];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Completion monitor: every ready pulse must match the oldest expected completion.
   initial begin
      sb_t           e;
      logic [CH-1:0] exp_r;
      forever begin
         @(negedge clock);
         if (req_ready !== '0 || req_error !== '0) begin
            if (sbq.size() == 0) begin
               check("spurious_ready", {req_ready, req_error}, 64'd0);
            end else begin
               e = sbq.pop_front();
               exp_r = '0;
               exp_r[e.ch] = 1'b1;
               check("ready_onehot", req_ready, exp_r);
               check("error_flag", req_error, e.err ? exp_r : '0);
               check("rdata", req_rdata, e.rdata);
            end
         end
      end
   end

   task automatic do_txn(input vec_t v);
      sb_t e;
      int  k;
      bit  stable;
      e.ch = v.ch; e.err = v.exp_err; e.rdata = v.exp_err ? '0 : v.rdata;
      sbq.push_back(e);
      req_instr[v.ch]            = v.instr;
      req_addr[v.ch*AW +: AW]    = v.addr;
      req_wdata[v.ch*DW +: DW]   = v.wdata;
      req_wstrb[v.ch*SW +: SW]   = v.wstrb;
      req_valid[v.ch]            = 1'b1;
      @(posedge clock); #1;
      check("grant_latency", mem_valid, 1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_fields", {mem_instr, mem_wstrb, mem_wdata}, {v.instr, v.wstrb, v.wdata});
      stable = 1'b1;
      k = 0;
      while (mem_valid === 1'b1 && k < 40) begin
         k++;
         mem_ready = (k == v.lat);
         mem_rdata = (k == v.lat) ? v.rdata : $urandom;
         if ({mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {v.instr, v.addr, v.wdata, v.wstrb})
            stable = 1'b0;
         // upstream noise while BUSY must not reach the downstream port
         req_addr  = {$urandom, $urandom, $urandom, $urandom};
         req_wdata = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clock); #1;
      end
      mem_ready = 1'b0;
      req_valid[v.ch] = 1'b0;
      check("stable", stable, 1);
      check("busy_cycles", k, v.exp_busy);
      @(posedge clock); #1;
   endtask

   task automatic contention();
      int            pend[CH];
      int            seq[CH];
      int            order[6];
      int            n, busy, left;
      bit            prev_v;
      sb_t           e;
      logic [AW-1:0] ea;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      order = '{0, 1, 2, 3, 0, 0};
`else
      order = '{0, 1, 0, 2, 0, 3};
`endif
      pend = '{3, 1, 1, 1};
      seq  = '{0, 0, 0, 0};
      n = 0; busy = 0; prev_v = 1'b0;
      for (int c = 0; c < CH; c++) begin
         req_addr[c*AW +: AW]  = {16'h0, 4'(c + 1), 12'h0};
         req_wstrb[c*SW +: SW] = '0;
         req_instr[c]          = 1'b0;
         req_valid[c]          = 1'b1;
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(posedge clock); #1;
         if (mem_valid && !prev_v) begin
            if (n < 6) begin
               ea = {16'h0, 4'(order[n] + 1), 12'(seq[order[n]])};
               check("grant_order", mem_addr, ea);
               e.ch = order[n]; e.err = 1'b0; e.rdata = {16'hA5A5, ea[15:0]};
               sbq.push_back(e);
            end else begin
               check("extra_grant", n, 6);
            end
            n++;
         end
         prev_v = mem_valid;
         busy = mem_valid ? busy + 1 : 0;
         mem_ready = (busy == 2);
         mem_rdata = {16'hA5A5, mem_addr[15:0]};
         left = 0;
         for (int c = 0; c < CH; c++) begin
            if (req_ready[c]) begin
               pend[c]--;
               seq[c]++;
               req_valid[c] = 1'b0;
               req_addr[c*AW +: AW] = {16'h0, 4'(c + 1), 12'(seq[c])};
            end else begin
               req_valid[c] = (pend[c] > 0);
            end
            left += pend[c];
         end
         if (left == 0) break;
      end
      mem_ready = 1'b0;
      req_valid = '0;
      check("grant_count", n, 6);
      @(posedge clock); #1;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_instr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_mem", {mem_valid, mem_instr, mem_wstrb, mem_addr}, 64'd0);
      check("reset_req", {req_ready, req_error, req_rdata}, 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      vecs[0] = '{1, 1'b0, 32'h0000_0100, 32'h0,         4'b0000, 3,  32'hDEAD_BEEF, 1'b0, 3};
      vecs[1] = '{0, 1'b0, 32'h0000_0200, 32'h1122_3344, 4'b0101, 2,  32'h0,         1'b0, 2};
      vecs[2] = '{2, 1'b1, 32'h0000_3000, 32'h0,         4'b0000, 1,  32'hCAFE_F00D, 1'b0, 1};
      vecs[3] = '{3, 1'b0, 32'h0000_0044, 32'h0,         4'b0000, 99, 32'h1234_5678, 1'b1, 8};
      vecs[4] = '{1, 1'b0, 32'h0000_0088, 32'h0,         4'b0000, 8,  32'h55AA_55AA, 1'b0, 8};
      vecs[5] = '{3, 1'b0, 32'h0000_0400, 32'hFFFF_0000, 4'b1111, 7,  32'h0BAD_CAFE, 1'b0, 7};
      for (int i = 0; i < 6; i++) do_txn(vecs[i]);

      contention();

      // reset while BUSY: outputs clear, a late mem_ready is ignored
      req_addr[2*AW +: AW] = 32'h0000_0ABC;
      req_wdata[2*DW +: DW] = 32'h7777_8888;
      req_wstrb[2*SW +: SW] = 4'b1001;
      req_valid[2] = 1'b1;
      @(posedge clock); #1;
      check("rst_pre_valid", mem_valid, 1);
      @(posedge clock); #1;
      reset = 1'b1;
      req_valid = '0;
      @(posedge clock); #1;
      check("rst_busy_mem", {mem_valid, mem_instr, mem_wstrb, mem_addr}, 64'd0);
      check("rst_busy_wdata", mem_wdata, 64'd0);
      check("rst_busy_req", {req_ready, req_error, req_rdata}, 64'd0);
      reset = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      @(posedge clock); #1;
      mem_ready = 1'b0;
      check("late_ready_ignored", {req_ready, mem_valid}, 64'd0);
      @(posedge clock); #1;
      check("late_ready_ignored2", {req_ready, req_error}, 64'd0);

      repeat (3) @(posedge clock);
      #1;
      check("sb_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
